// File: rtl/mul10bit_seq.sv
// mul10bit_seq: 10x10 unsigned shift-and-add multiplier, one iteration per clock.
// A single 10-bit adder with carry-out accumulates into the upper half of a
// 20-bit {acc, mplr} register pair, which shifts right once per iteration.
module mul10bit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  A,
    input  logic [9:0]  B,
    output logic        busy,
    output logic        done,
    output logic [19:0] prod,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  mcand_q, mcand_d;
    logic [9:0]  acc_q, acc_d;
    logic [9:0]  mplr_q, mplr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] prod_q, prod_d;
    logic        ovf_q, ovf_d;
    logic [10:0] sum;
    logic [19:0] shifted;

    // Next-state and datapath: the carry out of the adder becomes the new MSB after the shift.
    always_comb begin
        sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : 11'd0);
        shifted = {sum, mplr_q[9:1]};
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d = A;
                mplr_d  = B;
                acc_d   = 10'd0;
                cnt_d   = 4'd0;
                state_d = RUN;
            end
            RUN: begin
                acc_d  = shifted[19:10];
                mplr_d = shifted[9:0];
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    prod_d  = shifted;
                    ovf_d   = |shifted[19:10];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= 10'd0;
            acc_q   <= 10'd0;
            mplr_q  <= 10'd0;
            cnt_q   <= 4'd0;
            prod_q  <= 20'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign prod = prod_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_mul10bit_seq.sv
// tb_mul10bit_seq: scenario tasks with an expected-result queue for mul10bit_seq.
module tb_mul10bit_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  A, B;
    logic        busy, done, ovf;
    logic [19:0] prod;
    logic [20:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    mul10bit_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .prod(prod), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] expect_of(input logic [9:0] a, input logic [9:0] b);
        logic [19:0] p;
        p = 20'(a) * 20'(b);
        return {|p[19:10], p};
    endfunction

    function automatic logic [20:0] pop_exp();
        return (exp_q.size() == 0) ? 21'h1FFFFF : exp_q.pop_front();
    endfunction

    // Waits at negedges for done; k counts cycles since the accept negedge, bb counts cycles busy was low.
    task automatic wait_done(output int k, output int bb);
        k = 0;
        bb = 0;
        while (done !== 1'b1 && k < 30) begin
            if (busy !== 1'b1) bb++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (prod !== 20'd0) begin errors++; $display("FAIL reset_prod got=%h exp=0", prod); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_mult(input string name, input logic [9:0] a, input logic [9:0] b);
        int k, bb;
        logic [20:0] e;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        exp_q.push_back(expect_of(a, b));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = 10'($urandom); B = 10'($urandom);
        wait_done(k, bb);
        checks++; if (k != 10) begin errors++; $display("FAIL %s_latency got=%0d exp=10", name, k); end
        checks++; if (bb != 0) begin errors++; $display("FAIL %s_busy_low got=%0d cycles exp=0", name, bb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got=%b exp=0", name, busy); end
        e = pop_exp();
        checks++; if (prod !== e[19:0]) begin errors++; $display("FAIL %s_prod got=%h exp=%h", name, prod, e[19:0]); end
        checks++; if (ovf !== e[20]) begin errors++; $display("FAIL %s_ovf got=%b exp=%b", name, ovf, e[20]); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
        checks++; if (prod !== e[19:0]) begin errors++; $display("FAIL %s_prod_hold got=%h exp=%h", name, prod, e[19:0]); end
    endtask

    task automatic test_ignored_start();
        int k, bb;
        logic [20:0] e;
        @(negedge clk);
        A = 10'd10; B = 10'd2; start = 1'b1;
        exp_q.push_back(expect_of(10'd10, 10'd2));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            if (k == 4) begin start = 1'b1; A = 10'd7; B = 10'd7; end
            if (k == 5) start = 1'b0;
            @(negedge clk);
            k++;
        end
        checks++; if (k != 10) begin errors++; $display("FAIL ign_latency got=%0d exp=10", k); end
        e = pop_exp();
        checks++; if (prod !== e[19:0]) begin errors++; $display("FAIL ign_prod got=%h exp=%h", prod, e[19:0]); end
        start = 1'b1; A = 10'd7; B = 10'd7;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ign_idle got=done%b busy%b exp=00", done, busy); end
        exp_q.push_back(expect_of(10'd7, 10'd7));
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bb);
        checks++; if (k != 10) begin errors++; $display("FAIL ign_next_latency got=%0d exp=10", k); end
        checks++; if (bb != 0) begin errors++; $display("FAIL ign_next_busy got=%0d exp=0", bb); end
        e = pop_exp();
        checks++; if (prod !== e[19:0]) begin errors++; $display("FAIL ign_next_prod got=%h exp=%h", prod, e[19:0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        A = 10'd5; B = 10'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (prod !== 20'd0) begin errors++; $display("FAIL rstmid_prod got=%h exp=0", prod); end
        checks++; if (ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=ovf%b done%b exp=00", ovf, done); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d active cycles exp=0", seen); end
        test_mult("rst_after", 10'd3, 10'd5);
    endtask

    task automatic test_back_to_back();
        int k, bb;
        logic [20:0] e;
        @(negedge clk);
        A = 10'd2; B = 10'd3; start = 1'b1;
        exp_q.push_back(expect_of(10'd2, 10'd3));
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wait_done(k, bb);
            checks++; if (k != 10) begin errors++; $display("FAIL b2b%0d_latency got=%0d exp=10", i, k); end
            checks++; if (bb != 0) begin errors++; $display("FAIL b2b%0d_busy got=%0d exp=0", i, bb); end
            e = pop_exp();
            checks++; if (prod !== e[19:0]) begin errors++; $display("FAIL b2b%0d_prod got=%h exp=%h", i, prod, e[19:0]); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b%0d_busy_done got=%b exp=0", i, busy); end
            if (i == 2) start = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b%0d_idle got=busy%b done%b exp=00", i, busy, done); end
            if (i < 2) exp_q.push_back(expect_of(10'd2, 10'd3));
            @(negedge clk);
            checks++; if (busy !== (i < 2)) begin errors++; $display("FAIL b2b%0d_reaccept got=%b exp=%b", i, busy, i < 2); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL queue_empty got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_mult("basic", 10'd4, 10'd4);
        test_mult("max", 10'h3FF, 10'h3FF);
        test_mult("carry", 10'h200, 10'h003);
        test_mult("zero", 10'd0, 10'h3FF);
        test_mult("rand", 10'($urandom), 10'($urandom));
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
